// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// ----------------
// Hazard controller for a 5-stage RISC-V pipeline. It tracks its own
// destination-register tags for the EX, MEM and WB stages, fed from decode.
// From these tags it produces:
//   * registered forward selects (forwardA/forwardB) that are aligned with
//     the instruction occupying EX;
//   * combinational load-use stall and branch flush controls.
//
// Forward codes: 2'b00 regfile, 2'b10 EX/MEM result, 2'b01 MEM/WB result.
// Priority of controls: ext_stall > br_ctrl > load_use.
//
// Optional feature (macro HAZ_PERF_EN): adds saturating performance counters
// cnt_fwd, cnt_stall and cnt_flush. These counters freeze while ext_stall is
// high. When the macro is undefined, these ports do not exist.
//
// Ports:
//   clk, rstn        core clock, asynchronous active-low reset
//   id_*             decode-stage instruction fields
//   br_ctrl          taken branch/jump resolved in EX this cycle
//   ext_stall        global freeze
//   forwardA/B       operand selects for the instruction in EX (registered)
//   stall_pc/ifid    hold PC and IF/ID (combinational)
//   flush_ifid/idex  clear IF/ID, bubble into ID/EX (combinational)
//   dbg_tags         observation of the stage tags {wb, mem, ex}; each tag is
//                    {valid, rd, regwrite, memread}
//   cnt_*            performance counters (HAZ_PERF_EN only)
//
// There is no valid/ready handshake in this block. Every input is sampled
// every cycle, and ext_stall is the only mechanism for back-pressure.
module hazard_fwd_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      id_valid,
  input  logic [REG_AW-1:0]         id_rs1,
  input  logic [REG_AW-1:0]         id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      br_ctrl,
  input  logic                      ext_stall,
  output logic [1:0]                forwardA,
  output logic [1:0]                forwardB,
  output logic                      stall_pc,
  output logic                      stall_ifid,
  output logic                      flush_ifid,
  output logic                      flush_idex,
  output logic [3*(REG_AW+3)-1:0]   dbg_tags
`ifdef HAZ_PERF_EN
  ,
  output logic [CNT_W-1:0]          cnt_fwd,
  output logic [CNT_W-1:0]          cnt_stall,
  output logic [CNT_W-1:0]          cnt_flush
`endif
);

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } tag_t;

  tag_t ex_tag, mem_tag, wb_tag;
  tag_t id_tag;

  logic       load_use;
  logic [1:0] fwd_a_next, fwd_b_next;

  // A tag writes r when it is valid, it writes a register, and its destination
  // is r. Register x0 never counts as written, so it is never forwarded.
  function automatic logic tag_writes(input tag_t t, input logic [REG_AW-1:0] r);
    return t.valid & t.regwrite & (t.rd == r) & (r != '0);
  endfunction

  // EX is checked before MEM because EX holds the youngest producer. A WB
  // producer is not forwarded: the regfile reads with write-first behaviour.
  function automatic logic [1:0] fwd_select(input logic use_rs,
                                            input logic [REG_AW-1:0] rs,
                                            input tag_t ex_t,
                                            input tag_t mem_t);
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_rs) begin
      if (tag_writes(ex_t, rs))       sel = FWD_EXMEM;
      else if (tag_writes(mem_t, rs)) sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  always_comb begin
    id_tag          = '0;
    id_tag.valid    = id_valid;
    id_tag.rd       = id_rd;
    id_tag.regwrite = id_regwrite;
    id_tag.memread  = id_memread;
  end

  always_comb begin
    load_use   = id_valid & ex_tag.memread &
                 ((id_use_rs1 & tag_writes(ex_tag, id_rs1)) |
                  (id_use_rs2 & tag_writes(ex_tag, id_rs2)));
    // A taken branch squashes the ID instruction, so no stall is issued with it.
    stall_pc   = load_use & ~br_ctrl & ~ext_stall;
    stall_ifid = load_use & ~br_ctrl & ~ext_stall;
    flush_ifid = br_ctrl & ~ext_stall;
    flush_idex = (br_ctrl | load_use) & ~ext_stall;
    fwd_a_next = fwd_select(id_use_rs1, id_rs1, ex_tag, mem_tag);
    fwd_b_next = fwd_select(id_use_rs2, id_rs2, ex_tag, mem_tag);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_tag   <= '0;
      mem_tag  <= '0;
      wb_tag   <= '0;
      forwardA <= FWD_RF;
      forwardB <= FWD_RF;
    end else if (!ext_stall) begin
      mem_tag <= ex_tag;
      wb_tag  <= mem_tag;
      if (flush_idex) begin
        ex_tag   <= '0;
        forwardA <= FWD_RF;
        forwardB <= FWD_RF;
      end else begin
        ex_tag   <= id_tag;
        forwardA <= fwd_a_next;
        forwardB <= fwd_b_next;
      end
    end
  end

  assign dbg_tags = {wb_tag, mem_tag, ex_tag};

`ifdef HAZ_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_fwd   <= '0;
      cnt_stall <= '0;
      cnt_flush <= '0;
    end else if (!ext_stall) begin
      if (((forwardA != FWD_RF) || (forwardB != FWD_RF)) && (cnt_fwd != CNT_MAX))
        cnt_fwd <= cnt_fwd + 1'b1;
      if (stall_pc && (cnt_stall != CNT_MAX))
        cnt_stall <= cnt_stall + 1'b1;
      if (flush_ifid && (cnt_flush != CNT_MAX))
        cnt_flush <= cnt_flush + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

  localparam int AW = 5;
  localparam int TW = AW + 3;
  localparam int W  = 8 + 3 * TW;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          br_ctrl, ext_stall;
  logic [1:0]    forwardA, forwardB;
  logic          stall_pc, stall_ifid, flush_ifid, flush_idex;
  logic [3*TW-1:0] dbg_tags;
`ifdef HAZ_PERF_EN
  logic [31:0]   cnt_fwd, cnt_stall, cnt_flush;
`endif

  hazard_fwd_unit #(.REG_AW(AW), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .br_ctrl(br_ctrl), .ext_stall(ext_stall),
    .forwardA(forwardA), .forwardB(forwardB),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .dbg_tags(dbg_tags)
`ifdef HAZ_PERF_EN
    , .cnt_fwd(cnt_fwd), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
`endif
  );

  // Reference model: in-flight instructions at EX (0), MEM (1) and WB (2).
  logic          m_v[3];
  logic [AW-1:0] m_rd[3];
  logic          m_rw[3];
  logic          m_mr[3];
  logic [1:0]    m_fa, m_fb;
  logic          last_hold;

  logic [W-1:0] exp_q[$];
  int n_compared = 0;
  int n_mismatch = 0;
  logic rst_next = 1'b0;

  function automatic logic produces(input int k, input logic [AW-1:0] r);
    return m_v[k] && m_rw[k] && (m_rd[k] == r) && (r != 0);
  endfunction

  // The youngest in-flight producer wins; WB is never a source.
  function automatic logic [1:0] model_fwd(input logic use_rs, input logic [AW-1:0] r);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs)
      for (int k = 1; k >= 0; k--)
        if (produces(k, r)) sel = (k == 0) ? 2'b10 : 2'b01;
    return sel;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 0; m_rd[k] = '0; m_rw[k] = 0; m_mr[k] = 0;
    end
    m_fa = 2'b00; m_fb = 2'b00;
  endtask

  // Driver: applies one cycle of ID stimulus at the negedge, queues the
  // expected observable state for this cycle, then advances the model.
  task automatic drive(input logic v, input logic [AW-1:0] rs1, input logic u1,
                       input logic [AW-1:0] rs2, input logic u2,
                       input logic [AW-1:0] rd, input logic rw, input logic mr,
                       input logic br, input logic es);
    logic lu, e_stall, e_fif, e_fid;
    logic [1:0] na, nb;
    logic [3*TW-1:0] e_tags;
    @(negedge clk);
    rstn = rst_next;
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr; br_ctrl = br; ext_stall = es;
    if (!rstn) model_clear();
    lu      = v && m_mr[0] && ((u1 && produces(0, rs1)) || (u2 && produces(0, rs2)));
    e_stall = lu && !br && !es;
    e_fif   = br && !es;
    e_fid   = (br || lu) && !es;
    e_tags  = {m_v[2], m_rd[2], m_rw[2], m_mr[2],
               m_v[1], m_rd[1], m_rw[1], m_mr[1],
               m_v[0], m_rd[0], m_rw[0], m_mr[0]};
    exp_q.push_back({m_fa, m_fb, e_stall, e_stall, e_fif, e_fid, e_tags});
    last_hold = e_stall || es;
    if (rstn && !es) begin
      na = model_fwd(u1, rs1);
      nb = model_fwd(u2, rs2);
      for (int k = 2; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_rw[k] = m_rw[k-1]; m_mr[k] = m_mr[k-1];
      end
      if (e_fid) begin
        m_v[0] = 0; m_rd[0] = '0; m_rw[0] = 0; m_mr[0] = 0;
        m_fa = 2'b00; m_fb = 2'b00;
      end else begin
        m_v[0] = v; m_rd[0] = rd; m_rw[0] = rw; m_mr[0] = mr;
        m_fa = na; m_fb = nb;
      end
    end
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [W-1:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        act_v = {forwardA, forwardB, stall_pc, stall_ifid, flush_ifid, flush_idex, dbg_tags};
        n_compared++;
        if (act_v !== exp_v) begin
          n_mismatch++;
          $display("FAIL cycle_chk #%0d t=%0t: got fA=%b fB=%b st=%b%b fl=%b%b tags=%h, expected fA=%b fB=%b st=%b%b fl=%b%b tags=%h",
                   n_compared, $time,
                   act_v[W-1:W-2], act_v[W-3:W-4], act_v[W-5], act_v[W-6], act_v[W-7], act_v[W-8], act_v[3*TW-1:0],
                   exp_v[W-1:W-2], exp_v[W-3:W-4], exp_v[W-5], exp_v[W-6], exp_v[W-7], exp_v[W-8], exp_v[3*TW-1:0]);
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] r1, r2, rd;
    logic v, u1, u2, rw, mr, br, es;
    int waited;
    model_clear();
    last_hold = 0;
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = '0; id_regwrite = 0; id_memread = 0; br_ctrl = 0; ext_stall = 0;

    // reset state
    rst_next = 0;
    nop(); nop();
    rst_next = 1;
    nop();

    // addi x5 ; add x6,x5,x1
    drive(1, 0, 1, 0, 0, 5, 1, 0, 0, 0);
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    nop();
    // addi x5 ; nop ; sub x7,x1,x5
    drive(1, 0, 1, 0, 0, 5, 1, 0, 0, 0);
    nop();
    drive(1, 1, 1, 5, 1, 7, 1, 0, 0, 0);
    nop();
    // lw x8 ; add x9,x8,x8 (held one cycle by the stall)
    drive(1, 2, 1, 0, 0, 8, 1, 1, 0, 0);
    drive(1, 8, 1, 8, 1, 9, 1, 0, 0, 0);
    drive(1, 8, 1, 8, 1, 9, 1, 0, 0, 0);
    nop();
    // writer of x0, then reader of x0
    drive(1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 1, 3, 1, 0, 0, 0);
    nop();
    // branch coincident with load-use
    drive(1, 2, 1, 0, 0, 8, 1, 1, 0, 0);
    drive(1, 8, 1, 1, 1, 9, 1, 0, 1, 0);
    nop();
    // ext_stall held for 3 cycles during a load-use hazard
    drive(1, 2, 1, 0, 0, 8, 1, 1, 0, 0);
    drive(1, 8, 1, 8, 1, 9, 1, 0, 0, 1);
    drive(1, 8, 1, 8, 1, 9, 1, 0, 0, 1);
    drive(1, 8, 1, 8, 1, 9, 1, 0, 0, 1);
    drive(1, 8, 1, 8, 1, 9, 1, 0, 0, 0);
    drive(1, 8, 1, 8, 1, 9, 1, 0, 0, 0);
    // reset during operation
    drive(1, 0, 1, 0, 0, 5, 1, 0, 0, 0);
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
    rst_next = 0;
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
    rst_next = 1;
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
    drive(1, 5, 1, 5, 1, 7, 1, 0, 0, 0);
    nop();

    // randomized traffic; a held ID instruction is repeated
    v = 0; r1 = 0; r2 = 0; u1 = 0; u2 = 0; rd = 0; rw = 0; mr = 0;
    for (int i = 0; i < 600; i++) begin
      if (!last_hold) begin
        v  = ($urandom_range(0, 7) != 0);
        r1 = AW'($urandom_range(0, 4));
        r2 = AW'($urandom_range(0, 4));
        u1 = ($urandom_range(0, 3) != 0);
        u2 = ($urandom_range(0, 1) != 0);
        rd = AW'($urandom_range(0, 4));
        rw = ($urandom_range(0, 3) != 0);
        mr = rw && ($urandom_range(0, 2) == 0);
      end
      br = ($urandom_range(0, 9) == 0);
      es = ($urandom_range(0, 7) == 0);
      rst_next = ($urandom_range(0, 99) != 0);
      drive(v, r1, u1, r2, u2, rd, rw, mr, br, es);
    end
    rst_next = 1;
    nop();

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #5;
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatch++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
